// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: machine word, decoded control packet and the
// occupancy state of the IE/MEM latch.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LDB  = 4'h2,
        OP_STB  = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'ha,
        OP_STI  = 4'hb,
        OP_JMP  = 4'hc,
        OP_SHF  = 4'hd,
        OP_LEA  = 4'he,
        OP_TRAP = 4'hf
    } lc3b_opcode;

    // Everything downstream stages need from decode, packed into one word.
    typedef struct packed {
        lc3b_opcode  opcode;
        logic [2:0]  dest;
        logic [2:0]  src1;
        logic        load_regfile;
        logic        mem_read;
        logic        mem_write;
        logic        indirect;
        logic [1:0]  width;
    } lc3b_ipacket;

    typedef enum logic [1:0] {
        STAGE_EMPTY    = 2'd0,
        STAGE_FULL     = 2'd1,
        STAGE_INDIRECT = 2'd2
    } lc3b_stage_state;

endpackage

// File: rtl/indir_ctl.sv
// Occupancy FSM and indirection-level counter for the IE/MEM latch.
// Handshake: a packet moves when valid and ready are both high on a rising edge.
module indir_ctl
    import lc3b_types::*;
#(
    parameter int MAX_INDIR = 2,
    localparam int CW = $clog2(MAX_INDIR + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            out_ready,
    input  logic            mem_resp,
    input  logic [CW-1:0]   in_indir_cnt,
    output logic            in_ready,
    output logic            capture,
    output logic            addr_load,
    output lc3b_stage_state state,
    output logic [CW-1:0]   indir_left
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INDIR);

    logic [CW-1:0] load_cnt;

    assign load_cnt  = (in_indir_cnt > MAX_CNT) ? MAX_CNT : in_indir_cnt;
    assign in_ready  = (state == STAGE_EMPTY) | ((state == STAGE_FULL) & out_ready);
    assign capture   = in_valid & in_ready & ~flush;
    assign addr_load = (state == STAGE_INDIRECT) & mem_resp & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= STAGE_EMPTY;
            indir_left <= '0;
        end else if (flush) begin
            state      <= STAGE_EMPTY;
            indir_left <= '0;
        end else if (capture) begin
            indir_left <= load_cnt;
            state      <= (load_cnt != '0) ? STAGE_INDIRECT : STAGE_FULL;
        end else begin
            case (state)
                STAGE_FULL: begin
                    if (out_ready) state <= STAGE_EMPTY;
                end
                // out_ready is deliberately ignored until the last pointer lands.
                STAGE_INDIRECT: begin
                    if (mem_resp) begin
                        indir_left <= indir_left - CW'(1);
                        if (indir_left == CW'(1)) state <= STAGE_FULL;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ie_mem_latch_p.sv
// IE/MEM pipeline latch: holds one packet and resolves memory indirection by
// reloading the address lane with each returned pointer.
module ie_mem_latch_p
    import lc3b_types::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_LANES = 3,
    parameter int ADDR_LANE = 1,
    parameter int MAX_INDIR = 2,
    localparam int CW = $clog2(MAX_INDIR + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  lc3b_ipacket                       in_ipacket,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]  in_lane,
    input  logic [CW-1:0]                     in_indir_cnt,
    input  logic                              mem_resp,
    input  logic [DATA_W-1:0]                 mem_rdata,
    output logic                              out_valid,
    input  logic                              out_ready,
    output lc3b_ipacket                       out_ipacket,
    output logic [NUM_LANES-1:0][DATA_W-1:0]  out_lane,
    output logic                              hold,
    output logic [CW-1:0]                     indir_left
);

    logic                             capture;
    logic                             addr_load;
    lc3b_stage_state                  state;
    logic [NUM_LANES-1:0][DATA_W-1:0] lane_q;
    lc3b_ipacket                      ipacket_q;

    indir_ctl #(
        .MAX_INDIR (MAX_INDIR)
    ) u_indir_ctl (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .mem_resp     (mem_resp),
        .in_indir_cnt (in_indir_cnt),
        .in_ready     (in_ready),
        .capture      (capture),
        .addr_load    (addr_load),
        .state        (state),
        .indir_left   (indir_left)
    );

    // Payload survives flush; only a capture or a pointer return rewrites it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q    <= '0;
            ipacket_q <= '0;
        end else if (capture) begin
            lane_q    <= in_lane;
            ipacket_q <= in_ipacket;
        end else if (addr_load) begin
            lane_q[ADDR_LANE] <= mem_rdata;
        end
    end

    assign out_valid   = (state != STAGE_EMPTY);
    assign hold        = (state == STAGE_INDIRECT);
    assign out_lane    = lane_q;
    assign out_ipacket = ipacket_q;

endmodule

// File: tb/tb_ie_mem_latch_p.sv
// Directed and randomized checks of ie_mem_latch_p against an occupancy model.
module tb_ie_mem_latch_p;
    import lc3b_types::*;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    lc3b_ipacket       in_ipacket;
    logic [2:0][15:0]  in_lane;
    logic [1:0]        in_indir_cnt;
    logic              mem_resp;
    logic [15:0]       mem_rdata;
    logic              out_valid;
    logic              out_ready;
    lc3b_ipacket       out_ipacket;
    logic [2:0][15:0]  out_lane;
    logic              hold;
    logic [1:0]        indir_left;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: is a packet held, how many pointer returns it still needs.
    logic        m_valid;
    int          m_pend;
    logic [15:0] m_lane [3];
    logic [15:0] m_pkt;

    ie_mem_latch_p dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ipacket   (in_ipacket),
        .in_lane      (in_lane),
        .in_indir_cnt (in_indir_cnt),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ipacket  (out_ipacket),
        .out_lane     (out_lane),
        .hold         (hold),
        .indir_left   (indir_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_pend  = 0;
        m_pkt   = '0;
        for (int i = 0; i < 3; i++) m_lane[i] = '0;
    endtask

    task automatic model_capture();
        m_valid = 1'b1;
        m_pend  = (in_indir_cnt > 2) ? 2 : int'(in_indir_cnt);
        m_pkt   = in_ipacket;
        for (int i = 0; i < 3; i++) m_lane[i] = in_lane[i];
    endtask

    task automatic model_step();
        if (flush) begin
            m_valid = 1'b0;
            m_pend  = 0;
        end else if (!m_valid) begin
            if (in_valid) model_capture();
        end else if (m_pend != 0) begin
            if (mem_resp) begin
                m_lane[1] = mem_rdata;
                m_pend    = m_pend - 1;
            end
        end else if (out_ready) begin
            if (in_valid) model_capture();
            else m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic exp_ready;
        exp_ready = !m_valid || (m_pend == 0 && out_ready);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("hold", 32'(hold), 32'(m_valid && m_pend != 0));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("indir_left", 32'(indir_left), 32'(m_pend));
        chk("out_ipacket", 32'(out_ipacket), 32'(m_pkt));
        for (int i = 0; i < 3; i++) chk($sformatf("out_lane%0d", i), 32'(out_lane[i]), 32'(m_lane[i]));
    endtask

    task automatic do_cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] cnt, input logic [15:0] l0,
                         input logic [15:0] l1, input logic [15:0] l2, input logic ordy,
                         input logic resp, input logic [15:0] rd, input logic fl);
        in_valid     = v;
        in_indir_cnt = cnt;
        in_lane[0]   = l0;
        in_lane[1]   = l1;
        in_lane[2]   = l2;
        in_ipacket   = lc3b_ipacket'(16'($urandom));
        out_ready    = ordy;
        mem_resp     = resp;
        mem_rdata    = rd;
        flush        = fl;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_hold", 32'(hold), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_lane1", 32'(out_lane[1]), 0);
        reset = 1'b0;

        // Direct packet: visible one cycle later, drained on the following edge.
        drive(1, 0, 16'h1111, 16'h2222, 16'h3333, 1, 0, 0, 0);
        do_cycle();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("d_out_valid", 32'(out_valid), 1);
        chk("d_hold", 32'(hold), 0);
        chk("d_lane0", 32'(out_lane[0]), 32'h1111);
        chk("d_lane2", 32'(out_lane[2]), 32'h3333);
        do_cycle();
        chk("d_empty", 32'(out_valid), 0);

        // Two levels of indirection; in_valid and out_ready must be ignored meanwhile.
        drive(1, 2, 16'haaaa, 16'h0100, 16'hcccc, 1, 0, 0, 0);
        do_cycle();
        chk("i2_left2", 32'(indir_left), 2);
        drive(1, 1, 16'h9999, 16'h9999, 16'h9999, 1, 1, 16'h4000, 0);
        do_cycle();
        chk("i2_left1", 32'(indir_left), 1);
        chk("i2_lane1a", 32'(out_lane[1]), 32'h4000);
        drive(1, 1, 16'h9999, 16'h9999, 16'h9999, 1, 1, 16'h5000, 0);
        do_cycle();
        chk("i2_hold_off", 32'(hold), 0);
        chk("i2_lane1b", 32'(out_lane[1]), 32'h5000);
        chk("i2_lane0", 32'(out_lane[0]), 32'haaaa);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        do_cycle();

        // Requested depth above MAX_INDIR (largest encodable count) clamps to 2.
        drive(1, 3, 16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 0);
        do_cycle();
        chk("clamp_left", 32'(indir_left), 2);
        drive(0, 0, 0, 0, 0, 1, 1, 16'h7000, 0);
        do_cycle();
        chk("clamp_still_hold", 32'(hold), 1);
        do_cycle();
        chk("clamp_done", 32'(hold), 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        do_cycle();

        // Back-to-back direct packets with out_ready held high.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 16'($urandom), 16'($urandom), 16'($urandom), 1, 0, 0, 0);
            do_cycle();
            chk("b2b_in_ready", 32'(in_ready), 1);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        do_cycle();

        // Flush during indirection beats capture and pointer return.
        drive(1, 2, 16'h1234, 16'h5678, 16'h9abc, 1, 0, 0, 0);
        do_cycle();
        drive(1, 0, 16'hffff, 16'hffff, 16'hffff, 1, 1, 16'hdead, 1);
        do_cycle();
        chk("flush_empty", 32'(out_valid), 0);
        chk("flush_hold", 32'(hold), 0);
        chk("flush_lane1", 32'(out_lane[1]), 32'h5678);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle();

        // Asynchronous reset in the middle of an indirection.
        drive(1, 2, 16'h0bad, 16'h0bee, 16'h0cab, 0, 0, 0, 0);
        do_cycle();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_hold", 32'(hold), 0);
        #2;
        reset = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 1, 1, 16'hbeef, 0);
        do_cycle();
        do_cycle();
        chk("arst_lane1", 32'(out_lane[1]), 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
                  16'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 9) < 6), $urandom_range(0, 1),
                  16'($urandom), ($urandom_range(0, 15) == 0));
            do_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
